dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit sitting between the core datapath and the word-only data memory (`dmem`). It accepts byte, halfword and word load/store requests from the core and drives the `dmem` port: word address, `din`, `mem_read` and `mem_write`. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores use a two-cycle read-modify-write, because `dmem` only writes whole, aligned words.

## Interface
- `DMEM_ADDR_WIDTH`, 10, word-address width of the attached `dmem`
- `clk` input 1: rising-edge clock, shared with `dmem`
- `reset` input 1: asynchronous, active-high reset
- `req_valid` input 1: core request present
- `req_ready` output 1: unit can accept a request (high only in IDLE)
- `req_we` input 1: 1 = store, 0 = load
- `req_size` input 3: RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- `req_addr` input 32: byte address
- `req_wdata` input 32: store data, right-aligned
- `rsp_valid` output 1: one-cycle completion pulse
- `rsp_rdata` output 32: extended load data (0 for stores and errors)
- `rsp_err` output 1: illegal size or misaligned access, valid with `rsp_valid`
- `dmem_addr` output DMEM_ADDR_WIDTH: word address = `req_addr[DMEM_ADDR_WIDTH+1:2]`
- `dmem_din` output 32: write data to `dmem`
- `dmem_read` output 1: `mem_read` to `dmem`
- `dmem_write` output 1: `mem_write` to `dmem`
- `dmem_dout` input 32: combinational read data from `dmem`

## Operation
- FSM states: IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP.
- Acceptance happens on the rising edge where `req_valid && req_ready`. At that edge the unit registers the address, size, store flag and write data.
- Next state after acceptance:
  - Error: RESP with `rsp_err`=1.
  - Load: LOAD.
  - SW: STORE.
  - SB/SH: RMW_RD.
- Per-state behaviour:
  - LOAD: `dmem_read`=1. Select the byte/half lane from `addr[1:0]`, extend it, register into `rsp_rdata`, go to RESP.
  - STORE: `dmem_write`=1, `dmem_din` = registered wdata, go to RESP.
  - RMW_RD: `dmem_read`=1. Merge the wdata lane into `dmem_dout`, register the result as `dmem_din`, go to RMW_WR.
  - RMW_WR: `dmem_write`=1, go to RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. There is no response backpressure.
- Illegal encodings always produce `rsp_err`=1 with no `dmem` access:
  - loads with size 011, 110 or 111;
  - stores with `req_size[2]`=1 or size 011.
- Address bits above `DMEM_ADDR_WIDTH+1` are ignored, so addresses wrap modulo the memory size.
- `dmem_read`/`dmem_write` are decoded from the state register only (Moore outputs). They are never both 1, and both are 0 in IDLE and RESP.
- On error or store, `rsp_rdata` is 0.

## Timing
- Let c be the acceptance cycle. `rsp_valid` is high in:
  - c+1 for an error;
  - c+2 for a load or SW;
  - c+3 for SB/SH.
- `req_ready` returns high the cycle after RESP. Back-to-back loads therefore complete every 3 cycles.
- Every store asserts `dmem_write` for exactly one cycle.
- `dmem_addr` and `dmem_din` come from registers and are stable through the whole access.
- Reset values:
  - state IDLE;
  - `req_ready`=1;
  - every other output 0, including `dmem_addr` and `dmem_din`.
- Reset asserted in any state, including mid-RMW, forces IDLE immediately, and no response is issued.
- If reset is asserted before the write edge in STORE or RMW_WR, `dmem_write` is already 0 at that edge and memory is unchanged.

## Configuration
- Macro: `DMEM_LSU_MISALIGN_CHK_EN`.
- Defined: misaligned accesses return `rsp_err`=1 at c+1 with no `dmem` access.
  - Halfword is misaligned when `addr[0]`=1.
  - Word is misaligned when `addr[1:0]`≠0.
- Undefined: low address bits are forced to alignment and the access proceeds normally. `rsp_err` only reflects illegal sizes.
  - Halfword uses `addr[1]` only.
  - Word ignores `addr[1:0]`.

## Structure
- `dmem_lsu_pkg` holds:
  - the FSM state enum;
  - size localparams `LSU_SZ_B`, `LSU_SZ_H`, `LSU_SZ_W`, `LSU_SZ_BU`, `LSU_SZ_HU`.
- One combinational sub-module, `dmem_lsu_align`, does load lane extraction/extension and store lane merging from (size, `addr[1:0]`, word, wdata). The parent keeps the FSM and all registers.

## Test plan
All scenarios preload `dmem` word 1 with 0x8899AABB.
- LB at 0x7 -> `rsp_valid` at c+2, `rsp_rdata`=0xFFFFFF88, `rsp_err`=0.
- LHU at 0x4 -> `rsp_rdata`=0x0000AABB. LW at 0x4 -> 0x8899AABB.
- SH 0x00001234 at 0x6 -> `dmem_read` at c+1, `dmem_write` for one cycle at c+2 with `dmem_din`=0x1234AABB, `rsp_valid` at c+3; a following LW at 0x4 returns 0x1234AABB.
- With macro defined, LW at 0x5 -> `rsp_err`=1 at c+1, no `dmem_read`/`dmem_write`. With macro undefined, the same request returns 0x8899AABB at c+2.
- Load with size 111 -> `rsp_err`=1 at c+1 in both builds.
- Assert reset during RMW_WR of SB 0xFF at 0x4 -> `dmem_write` 0 at the edge, word stays 0x8899AABB, no `rsp_valid`, `req_ready`=1 after reset releases.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// dmem_lsu_pkg: shared FSM state encoding, RISC-V funct3 access-size codes
// and request legality helpers for the dmem load/store unit.
package dmem_lsu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STORE  = 3'd2,
        ST_RMW_RD = 3'd3,
        ST_RMW_WR = 3'd4,
        ST_RESP   = 3'd5
    } lsu_state_t;

    localparam logic [2:0] LSU_SZ_B  = 3'b000;
    localparam logic [2:0] LSU_SZ_H  = 3'b001;
    localparam logic [2:0] LSU_SZ_W  = 3'b010;
    localparam logic [2:0] LSU_SZ_BU = 3'b100;
    localparam logic [2:0] LSU_SZ_HU = 3'b101;

    // Stores have no unsigned variants, so any size[2] store is illegal.
    function automatic logic lsu_size_illegal(input logic we, input logic [2:0] size);
        if (we)
            return size[2] || (size == 3'b011);
        else
            return (size == 3'b011) || (size == 3'b110) || (size == 3'b111);
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] lo);
        if ((size == LSU_SZ_H) || (size == LSU_SZ_HU))
            return lo[0];
        else if (size == LSU_SZ_W)
            return lo != 2'b00;
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// dmem_lsu_align: purely combinational lane logic for the load/store unit.
// Extracts and sign/zero-extends the addressed byte or halfword of a loaded
// word, and merges store data into the addressed lane of an existing word.
// Halfword lanes are chosen by lane[1] alone; words ignore lane entirely.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword out of the memory word.
    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
    end

    // Extend the selected lane according to the access size.
    always_comb begin
        load_data = '0;
        case (size)
            LSU_SZ_B:  load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_SZ_BU: load_data = {24'h000000, byte_sel};
            LSU_SZ_H:  load_data = {{16{half_sel[15]}}, half_sel};
            LSU_SZ_HU: load_data = {16'h0000, half_sel};
            LSU_SZ_W:  load_data = word;
            default:   load_data = '0;
        endcase
    end

    // Overlay the right-aligned store data onto the addressed lane.
    always_comb begin
        merge_data = word;
        case (size)
            LSU_SZ_B: begin
                case (lane)
                    2'd0:    merge_data[7:0]   = wdata[7:0];
                    2'd1:    merge_data[15:8]  = wdata[7:0];
                    2'd2:    merge_data[23:16] = wdata[7:0];
                    default: merge_data[31:24] = wdata[7:0];
                endcase
            end
            LSU_SZ_H: begin
                if (lane[1])
                    merge_data[31:16] = wdata[15:0];
                else
                    merge_data[15:0]  = wdata[15:0];
            end
            LSU_SZ_W: merge_data = wdata;
            default:  merge_data = word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit between the core and a word-only data memory.
// Loads take one dmem read cycle; word stores one write cycle; byte and
// halfword stores do a read-modify-write (read+merge, then write).
// Optional build macro DMEM_LSU_MISALIGN_CHK_EN: when defined, misaligned
// halfword/word accesses are rejected with rsp_err; when undefined the low
// address bits are ignored as appropriate and the access proceeds.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_WIDTH = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_we,
    input  logic [2:0]                 req_size,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    output logic                       rsp_valid,
    output logic [31:0]                rsp_rdata,
    output logic                       rsp_err,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]                dmem_din,
    output logic                       dmem_read,
    output logic                       dmem_write,
    input  logic [31:0]                dmem_dout
);

    lsu_state_t                 state_q, state_d;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q;
    logic [1:0]                 lane_q;
    logic [2:0]                 size_q;
    logic [31:0]                wdata_q;
    logic [31:0]                din_q;
    logic [31:0]                rdata_q;
    logic                       err_q;

    logic                       accept;
    logic                       req_err;
    logic [31:0]                load_data;
    logic [31:0]                merge_data;
    logic                       unused_addr_hi;

    // Upper address bits are deliberately dropped so accesses wrap.
    assign unused_addr_hi = ^req_addr[31:DMEM_ADDR_WIDTH+2];

    assign accept = req_valid && (state_q == ST_IDLE);

`ifdef DMEM_LSU_MISALIGN_CHK_EN
    assign req_err = lsu_size_illegal(req_we, req_size) ||
                     lsu_misaligned(req_size, req_addr[1:0]);
`else
    assign req_err = lsu_size_illegal(req_we, req_size);
`endif

    dmem_lsu_align u_align (
        .size       (size_q),
        .lane       (lane_q),
        .word       (dmem_dout),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // Next-state decode for the access sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_d = ST_RESP;
                    else if (!req_we)
                        state_d = ST_LOAD;
                    else if (req_size == LSU_SZ_W)
                        state_d = ST_STORE;
                    else
                        state_d = ST_RMW_RD;
                end
            end
            ST_LOAD, ST_STORE, ST_RMW_WR: state_d = ST_RESP;
            ST_RMW_RD:                    state_d = ST_RMW_WR;
            ST_RESP:                      state_d = ST_IDLE;
            default:                      state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers: capture on accept, update per state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            din_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr[DMEM_ADDR_WIDTH+1:2];
                        lane_q  <= req_addr[1:0];
                        size_q  <= req_size;
                        wdata_q <= req_wdata;
                        err_q   <= req_err;
                        rdata_q <= '0;
                        // Word stores write straight from the request data.
                        if (!req_err && req_we && (req_size == LSU_SZ_W))
                            din_q <= req_wdata;
                    end
                end
                ST_LOAD:   rdata_q <= load_data;
                ST_RMW_RD: din_q   <= merge_data;
                ST_RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign dmem_addr  = addr_q;
    assign dmem_din   = din_q;
    assign dmem_read  = (state_q == ST_LOAD)  || (state_q == ST_RMW_RD);
    assign dmem_write = (state_q == ST_STORE) || (state_q == ST_RMW_WR);

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a behavioural word memory.
// Honours DMEM_LSU_MISALIGN_CHK_EN for the misaligned-access expectations.
module tb_dmem_lsu;

    localparam int unsigned AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_size = 3'b000;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_din;
    logic          dmem_read;
    logic          dmem_write;
    logic [31:0]   dmem_dout;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          mem_init = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_lsu #(.DMEM_ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_dout  (dmem_dout)
    );

    // Word memory: combinational read, write on the rising edge.
    assign dmem_dout = mem[dmem_addr];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            mem[1] <= 32'h8899AABB;
        end else if (dmem_write) begin
            mem[dmem_addr] <= dmem_din;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [2:0] sz, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd, input logic e,
                                input int lat, input int nr, input int nw);
        vec_t v;
        v.we = we; v.size = sz; v.addr = a; v.wdata = wd; v.exp_rdata = rd;
        v.exp_err = e; v.exp_lat = lat; v.exp_rd = nr; v.exp_wr = nw;
        return v;
    endfunction

    // Issue one request starting at a falling edge; report cycles from the
    // acceptance edge to rsp_valid (99 if it never came) and dmem activity.
    task automatic run_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                           output logic err, output int nrd, output int nwr,
                           output logic [31:0] din_wr, output logic pulse_after);
        int guard;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_we = we; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nrd = 0; nwr = 0; din_wr = '0;
        while (!rsp_valid && lat < 10) begin
            nrd += int'(dmem_read);
            nwr += int'(dmem_write);
            if (dmem_write) din_wr = dmem_din;
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = 99;
        rdata = rsp_rdata;
        err   = rsp_err;
        @(negedge clk);
        pulse_after = rsp_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[$];
        int          lat, nrd, nwr, quiet;
        logic [31:0] rdata, din_wr;
        logic        err, pulse;

        // LB/LBU/LH/LHU/LW on word 1 = 0x8899AABB
        vecs.push_back(mk(0, 3'b000, 32'h7, 0, 32'hFFFFFF88, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'b100, 32'h7, 0, 32'h00000088, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'b000, 32'h4, 0, 32'hFFFFFFBB, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'b100, 32'h5, 0, 32'h000000AA, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'b001, 32'h6, 0, 32'hFFFF8899, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'b101, 32'h4, 0, 32'h0000AABB, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'b010, 32'h4, 0, 32'h8899AABB, 0, 2, 1, 0));
`ifdef DMEM_LSU_MISALIGN_CHK_EN
        vecs.push_back(mk(0, 3'b010, 32'h5, 0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 3'b001, 32'h7, 0, 32'h0, 1, 1, 0, 0));
`else
        vecs.push_back(mk(0, 3'b010, 32'h5, 0, 32'h8899AABB, 0, 2, 1, 0));
        vecs.push_back(mk(0, 3'b001, 32'h7, 0, 32'hFFFF8899, 0, 2, 1, 0));
`endif
        // Illegal sizes
        vecs.push_back(mk(0, 3'b111, 32'h4, 0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 3'b011, 32'h4, 0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 3'b110, 32'h4, 0, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3'b100, 32'h4, 32'hFF, 32'h0, 1, 1, 0, 0));
        vecs.push_back(mk(1, 3'b011, 32'h4, 32'hFF, 32'h0, 1, 1, 0, 0));
        // Address wrap: 0x1004 maps to word 1
        vecs.push_back(mk(0, 3'b010, 32'h1004, 0, 32'h8899AABB, 0, 2, 1, 0));
        // Stores to word 2 then read-back
        vecs.push_back(mk(1, 3'b010, 32'h8, 32'hDEADBEEF, 32'h0, 0, 2, 0, 1));
        vecs.push_back(mk(0, 3'b010, 32'h8, 0, 32'hDEADBEEF, 0, 2, 1, 0));
        vecs.push_back(mk(1, 3'b000, 32'h9, 32'h12345655, 32'h0, 0, 3, 1, 1));
        vecs.push_back(mk(0, 3'b010, 32'h8, 0, 32'hDEAD55EF, 0, 2, 1, 0));
        vecs.push_back(mk(1, 3'b001, 32'hA, 32'h9999ABCD, 32'h0, 0, 3, 1, 1));
        vecs.push_back(mk(0, 3'b101, 32'hA, 0, 32'h0000ABCD, 0, 2, 1, 0));

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'b0, req_ready}, 32'h1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        check("rst_dmem_rw", {30'b0, dmem_read, dmem_write}, 32'h0);
        check("rst_dmem_addr", {22'b0, dmem_addr}, 32'h0);
        check("rst_dmem_din", dmem_din, 32'h0);
        mem_init = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            run_req(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                    lat, rdata, err, nrd, nwr, din_wr, pulse);
            check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_nrd", i), nrd, vecs[i].exp_rd);
            check($sformatf("v%0d_nwr", i), nwr, vecs[i].exp_wr);
            check($sformatf("v%0d_pulse", i), {31'b0, pulse}, 32'h0);
        end

        // Reset during RMW_WR of SB 0xFF at 0x4: no write, no response
        req_we = 1'b1; req_size = 3'b000; req_addr = 32'h4; req_wdata = 32'hFF; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rmwrst_read", {31'b0, dmem_read}, 32'h1);
        @(negedge clk);
        check("rmwrst_write_before", {31'b0, dmem_write}, 32'h1);
        #1 reset = 1'b1;
        #1;
        check("rmwrst_write_cleared", {31'b0, dmem_write}, 32'h0);
        check("rmwrst_ready_async", {31'b0, req_ready}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rmwrst_mem_word1", mem[1], 32'h8899AABB);
        quiet = 0;
        for (int k = 0; k < 4; k++) begin
            quiet += int'(rsp_valid);
            @(negedge clk);
        end
        check("rmwrst_no_rsp", quiet, 0);
        check("rmwrst_ready", {31'b0, req_ready}, 32'h1);

        // SH 0x1234 at 0x6: read at c+1, single write at c+2, rsp at c+3
        run_req(1'b1, 3'b001, 32'h6, 32'h00001234, lat, rdata, err, nrd, nwr, din_wr, pulse);
        check("sh_lat", lat, 3);
        check("sh_nrd", nrd, 1);
        check("sh_nwr", nwr, 1);
        check("sh_din", din_wr, 32'h1234AABB);
        check("sh_err", {31'b0, err}, 32'h0);
        check("sh_mem", mem[1], 32'h1234AABB);
        run_req(1'b0, 3'b010, 32'h4, 32'h0, lat, rdata, err, nrd, nwr, din_wr, pulse);
        check("sh_lw_rdata", rdata, 32'h1234AABB);
        check("sh_lw_lat", lat, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
